// File: rtl/branch_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// branch_hazard_ctrl
//
// Sequencing controller for the decode-stage branch resolver. The resolver
// reads the register file directly (no forwarding), so any control
// instruction whose source registers are still being produced in EX or MEM
// must wait. This block:
//   * stalls the front end and bubbles ID/EX until those producers retire,
//   * qualifies the resolver's taken result once the operands are valid,
//   * redirects the PC and squashes IF/ID for FLUSH_CYCLES cycles,
//   * raises a sticky watchdog flag when a single wait lasts MAX_STALL cycles.
//
// Parameters
//   FLUSH_CYCLES : cycles flush_if_id is held per taken branch/jump (1..4)
//   MAX_STALL    : stall cycles within one wait that set err_stall (1..15)
//   CNT_W        : width of the optional performance counters
//
// Optional feature (compile-time macro BR_PERF_CNT_EN)
//   Defined   : adds perf_stall / perf_taken saturating event counters.
//   Undefined : those ports and registers do not exist.
//
// Ports
//   clk            in   clock, all state on posedge
//   rst            in   synchronous reset, active-high
//   id_valid       in   IF/ID holds a valid instruction
//   id_instr[31:0] in   IF/ID instruction word
//   ex_valid       in   EX stage valid
//   ex_reg_write   in   EX instruction writes rd
//   ex_rd[4:0]     in   EX destination register
//   mem_valid      in   MEM stage valid
//   mem_reg_write  in   MEM instruction writes rd
//   mem_rd[4:0]    in   MEM destination register
//   br_raw         in   resolver taken output (conditional branches only)
//   stall_if       out  hold PC and IF/ID
//   bubble_ex      out  load NOP into ID/EX
//   flush_if_id    out  squash IF/ID contents
//   pc_redirect    out  PC mux selects branch/jump target
//   br_state[1:0]  out  FSM state: IDLE=00, WAIT=01, FLUSH=10
//   err_stall      out  sticky watchdog flag
//   perf_stall     out  (BR_PERF_CNT_EN) cycles with stall_if = 1
//   perf_taken     out  (BR_PERF_CNT_EN) cycles with pc_redirect = 1
//
// All outputs are Mealy (combinational from state and inputs) so the stall
// and redirect act in the same cycle the instruction sits in decode. Every
// output is forced low while rst is asserted.
// -----------------------------------------------------------------------------
module branch_hazard_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned MAX_STALL    = 3,
    parameter int unsigned CNT_W        = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [31:0]       id_instr,
    input  logic              ex_valid,
    input  logic              ex_reg_write,
    input  logic [4:0]        ex_rd,
    input  logic              mem_valid,
    input  logic              mem_reg_write,
    input  logic [4:0]        mem_rd,
    input  logic              br_raw,
    output logic              stall_if,
    output logic              bubble_ex,
    output logic              flush_if_id,
    output logic              pc_redirect,
    output logic [1:0]        br_state,
    output logic              err_stall
`ifdef BR_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]  perf_stall,
    output logic [CNT_W-1:0]  perf_taken
`endif
);

    // -------------------------------------------------------------------------
    // Elaboration-time parameter legality
    // -------------------------------------------------------------------------
    if ((FLUSH_CYCLES < 1) || (FLUSH_CYCLES > 4) ||
        (MAX_STALL < 1) || (MAX_STALL > 15) || (CNT_W < 1)) begin : g_bad_params
        $error("branch_hazard_ctrl: illegal FLUSH_CYCLES/MAX_STALL/CNT_W");
    end

    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    localparam logic [3:0] MAX_STALL_C = 4'(MAX_STALL);
    localparam logic [2:0] FL_INIT_C   = 3'(FLUSH_CYCLES - 1);
    localparam bit         FL_MULTI_C  = (FLUSH_CYCLES > 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_WAIT  = 2'b01,
        ST_FLUSH = 2'b10
    } state_e;

    // State registers and their next-state values
    state_e     state_q,    state_d;
    logic [3:0] wait_cnt_q, wait_cnt_d;
    logic [2:0] fl_cnt_q,   fl_cnt_d;
    logic       err_q;

    // Decode / hazard terms
    logic [6:0] op_s;
    logic       is_br_s, is_jalr_s, is_jal_s, ctrl_s;
    logic [4:0] rs1_s, rs2_s;
    logic       use_rs1_s, use_rs2_s;
    logic       haz_ex_s, haz_mem_s, hazard_s, take_s;

    // Unmasked output terms
    logic       stall_s, bubble_s, flush_s, redirect_s, err_set_s;

    // -------------------------------------------------------------------------
    // Instruction decode and source-register hazard detection
    // -------------------------------------------------------------------------
    assign op_s      = id_instr[6:0];
    assign is_br_s   = (op_s == OP_BR);
    assign is_jalr_s = (op_s == OP_JALR);
    assign is_jal_s  = (op_s == OP_JAL);
    assign ctrl_s    = id_valid & (is_br_s | is_jalr_s | is_jal_s);
    assign rs1_s     = id_instr[19:15];
    assign rs2_s     = id_instr[24:20];
    // JAL reads no register, JALR only rs1, conditional branches both.
    assign use_rs1_s = is_br_s | is_jalr_s;
    assign use_rs2_s = is_br_s;

    // x0 is never a real producer, so rd == 0 cannot create a hazard.
    assign haz_ex_s  = ex_valid & ex_reg_write & (ex_rd != 5'd0) &
                       ((use_rs1_s & (ex_rd == rs1_s)) |
                        (use_rs2_s & (ex_rd == rs2_s)));
    assign haz_mem_s = mem_valid & mem_reg_write & (mem_rd != 5'd0) &
                       ((use_rs1_s & (mem_rd == rs1_s)) |
                        (use_rs2_s & (mem_rd == rs2_s)));

    // WB is deliberately absent: the register file writes before it reads.
    assign hazard_s  = ctrl_s & (haz_ex_s | haz_mem_s);
    // Jumps always redirect; only conditional branches consult the resolver.
    assign take_s    = ctrl_s & ~hazard_s & (is_br_s ? br_raw : 1'b1);

    // -------------------------------------------------------------------------
    // Next-state and Mealy output logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        fl_cnt_d   = fl_cnt_q;
        stall_s    = 1'b0;
        bubble_s   = 1'b0;
        flush_s    = 1'b0;
        redirect_s = 1'b0;
        err_set_s  = 1'b0;

        case (state_q)
            // IDLE and WAIT share the decision logic: the cycle a wait ends
            // behaves exactly like a fresh arrival in IDLE.
            ST_IDLE, ST_WAIT: begin
                if (hazard_s) begin
                    stall_s  = 1'b1;
                    bubble_s = 1'b1;
                    state_d  = ST_WAIT;
                    if (state_q == ST_IDLE) begin
                        wait_cnt_d = 4'd1;
                    end else if (wait_cnt_q == 4'd15) begin
                        wait_cnt_d = 4'd15;
                    end else begin
                        wait_cnt_d = wait_cnt_q + 4'd1;
                    end
                    // wait_cnt_d counts stall cycles of this wait including
                    // the current one, so the flag shows on the cycle that
                    // reaches the limit.
                    err_set_s = (wait_cnt_d == MAX_STALL_C);
                end else if (take_s) begin
                    redirect_s = 1'b1;
                    flush_s    = 1'b1;
                    wait_cnt_d = 4'd0;
                    if (FL_MULTI_C) begin
                        state_d  = ST_FLUSH;
                        fl_cnt_d = FL_INIT_C;
                    end else begin
                        state_d  = ST_IDLE;
                        fl_cnt_d = 3'd0;
                    end
                end else begin
                    // Not taken, or the instruction was squashed while waiting.
                    state_d    = ST_IDLE;
                    wait_cnt_d = 4'd0;
                end
            end

            // Remaining squash cycles of a taken branch; decode is ignored.
            ST_FLUSH: begin
                flush_s = 1'b1;
                if (fl_cnt_q <= 3'd1) begin
                    state_d  = ST_IDLE;
                    fl_cnt_d = 3'd0;
                end else begin
                    fl_cnt_d = fl_cnt_q - 3'd1;
                end
            end

            default: begin
                state_d    = ST_IDLE;
                wait_cnt_d = 4'd0;
                fl_cnt_d   = 3'd0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State, counters and sticky watchdog flag
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            wait_cnt_q <= 4'd0;
            fl_cnt_q   <= 3'd0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            fl_cnt_q   <= fl_cnt_d;
            err_q      <= err_q | err_set_s;
        end
    end

    // Outputs are held low for the whole reset cycle, including mid-sequence.
    assign stall_if    = ~rst & stall_s;
    assign bubble_ex   = ~rst & bubble_s;
    assign flush_if_id = ~rst & flush_s;
    assign pc_redirect = ~rst & redirect_s;
    assign br_state    = rst ? 2'b00 : state_q;
    assign err_stall   = ~rst & (err_q | err_set_s);

`ifdef BR_PERF_CNT_EN
    logic [CNT_W-1:0] perf_stall_q;
    logic [CNT_W-1:0] perf_taken_q;

    // Saturating event counters for stall and redirect cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_q <= '0;
            perf_taken_q <= '0;
        end else begin
            if (stall_if && (perf_stall_q != {CNT_W{1'b1}})) begin
                perf_stall_q <= perf_stall_q + CNT_W'(1);
            end else begin
                perf_stall_q <= perf_stall_q;
            end
            if (pc_redirect && (perf_taken_q != {CNT_W{1'b1}})) begin
                perf_taken_q <= perf_taken_q + CNT_W'(1);
            end else begin
                perf_taken_q <= perf_taken_q;
            end
        end
    end

    assign perf_stall = perf_stall_q;
    assign perf_taken = perf_taken_q;
`endif

endmodule

// File: tb/tb_branch_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for branch_hazard_ctrl.
// Two instances share the same stimulus:
//   dut_a : FLUSH_CYCLES = 1, MAX_STALL = 3 (defaults)
//   dut_b : FLUSH_CYCLES = 3, MAX_STALL = 2
// Each directed step pushes the expected output vector of both instances
// into a queue; the vectors are popped and compared mid-cycle.
// Expected vector layout: {stall_if, bubble_ex, flush_if_id, pc_redirect,
//                          br_state[1:0], err_stall}
// -----------------------------------------------------------------------------
module tb_branch_hazard_ctrl;

    localparam logic [31:0] I_BEQ_X1_X2 = 32'h00208063;
    localparam logic [31:0] I_BNE_X0_X5 = 32'h00501063;
    localparam logic [31:0] I_JAL       = 32'h0000006F;
    localparam logic [31:0] I_JALR_X3   = 32'h00018067;
    localparam logic [31:0] I_ADD_RS1X1 = 32'h00008033;
    localparam logic [31:0] I_NOP       = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [31:0] id_instr;
    logic        ex_valid, ex_reg_write;
    logic [4:0]  ex_rd;
    logic        mem_valid, mem_reg_write;
    logic [4:0]  mem_rd;
    logic        br_raw;

    logic        stall_a, bubble_a, flush_a, redir_a, err_a;
    logic [1:0]  state_a;
    logic        stall_b, bubble_b, flush_b, redir_b, err_b;
    logic [1:0]  state_b;
`ifdef BR_PERF_CNT_EN
    logic [15:0] perf_stall_a, perf_taken_a, perf_stall_b, perf_taken_b;
`endif

    int checks = 0;
    int errors = 0;
    logic [6:0] q_a[$];
    logic [6:0] q_b[$];

    always #5 clk = ~clk;

    branch_hazard_ctrl #(.FLUSH_CYCLES(1), .MAX_STALL(3), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_instr(id_instr),
        .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_rd(ex_rd),
        .mem_valid(mem_valid), .mem_reg_write(mem_reg_write), .mem_rd(mem_rd),
        .br_raw(br_raw), .stall_if(stall_a), .bubble_ex(bubble_a),
        .flush_if_id(flush_a), .pc_redirect(redir_a), .br_state(state_a),
        .err_stall(err_a)
`ifdef BR_PERF_CNT_EN
        , .perf_stall(perf_stall_a), .perf_taken(perf_taken_a)
`endif
    );

    branch_hazard_ctrl #(.FLUSH_CYCLES(3), .MAX_STALL(2), .CNT_W(16)) dut_b (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_instr(id_instr),
        .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_rd(ex_rd),
        .mem_valid(mem_valid), .mem_reg_write(mem_reg_write), .mem_rd(mem_rd),
        .br_raw(br_raw), .stall_if(stall_b), .bubble_ex(bubble_b),
        .flush_if_id(flush_b), .pc_redirect(redir_b), .br_state(state_b),
        .err_stall(err_b)
`ifdef BR_PERF_CNT_EN
        , .perf_stall(perf_stall_b), .perf_taken(perf_taken_b)
`endif
    );

    function automatic logic [6:0] e7(input logic s, input logic b, input logic f,
                                      input logic r, input logic [1:0] st, input logic e);
        return {s, b, f, r, st, e};
    endfunction

    task automatic idle_in();
        id_valid = 1'b0; id_instr = I_NOP;
        ex_valid = 1'b0; ex_reg_write = 1'b0; ex_rd = 5'd0;
        mem_valid = 1'b0; mem_reg_write = 1'b0; mem_rd = 5'd0;
        br_raw = 1'b0;
    endtask

    task automatic instr_in(input logic [31:0] ins, input logic raw);
        id_valid = 1'b1; id_instr = ins; br_raw = raw;
    endtask

    task automatic ex_in(input logic v, input logic [4:0] rd);
        ex_valid = v; ex_reg_write = v; ex_rd = rd;
    endtask

    task automatic mem_in(input logic v, input logic [4:0] rd);
        mem_valid = v; mem_reg_write = v; mem_rd = rd;
    endtask

    // One clock cycle: push expectations, sample at negedge, advance past posedge.
    task automatic cyc(input string tag, input logic [6:0] ea, input logic [6:0] eb);
        logic [6:0] xa, xb, oa, ob;
        q_a.push_back(ea);
        q_b.push_back(eb);
        @(negedge clk);
        xa = q_a.pop_front();
        xb = q_b.pop_front();
        oa = {stall_a, bubble_a, flush_a, redir_a, state_a, err_a};
        ob = {stall_b, bubble_b, flush_b, redir_b, state_b, err_b};
        checks++;
        assert (oa === xa) else begin
            errors++;
            $error("FAIL %s dut_a observed=%b expected=%b", tag, oa, xa);
        end
        checks++;
        assert (ob === xb) else begin
            errors++;
            $error("FAIL %s dut_b observed=%b expected=%b", tag, ob, xb);
        end
        @(posedge clk);
        #1;
    endtask

    logic [6:0] z;
    logic [6:0] ze;

    initial begin
        z  = e7(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
        ze = e7(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1);
        idle_in();
        rst = 1'b1;

        // Reset state
        cyc("reset", z, z);
        rst = 1'b0;
        cyc("post_reset_idle", z, z);

        // 1: BEQ x1,x2, producer in EX, then MEM, then gone; taken
        instr_in(I_BEQ_X1_X2, 1'b1); ex_in(1'b1, 5'd1);
        cyc("t1_stall_ex", e7(1,1,0,0,2'b00,0), e7(1,1,0,0,2'b00,0));
        ex_in(1'b0, 5'd0); mem_in(1'b1, 5'd1);
        cyc("t1_stall_mem", e7(1,1,0,0,2'b01,0), e7(1,1,0,0,2'b01,1));
        mem_in(1'b0, 5'd0);
        cyc("t1_redirect", e7(0,0,1,1,2'b01,0), e7(0,0,1,1,2'b01,1));
        idle_in();
        cyc("t1_flush2", z, e7(0,0,1,0,2'b10,1));
        cyc("t1_flush3", z, e7(0,0,1,0,2'b10,1));
        cyc("t1_done", z, ze);

        // 2: BNE x0,x5; ex_rd = 0 is harmless, MEM rd 5 stalls; not taken
        instr_in(I_BNE_X0_X5, 1'b0); ex_in(1'b1, 5'd0); mem_in(1'b1, 5'd5);
        cyc("t2_stall_mem", e7(1,1,0,0,2'b00,0), e7(1,1,0,0,2'b00,1));
        mem_in(1'b0, 5'd0);
        cyc("t2_not_taken", e7(0,0,0,0,2'b01,0), e7(0,0,0,0,2'b01,1));
        idle_in();
        cyc("t2_done", z, ze);

        // 3: JAL with unrelated EX writer; immediate redirect, br_raw ignored
        instr_in(I_JAL, 1'b0); ex_in(1'b1, 5'd3);
        cyc("t3_jal_redirect", e7(0,0,1,1,2'b00,0), e7(0,0,1,1,2'b00,1));
        idle_in();
        cyc("t3_flush2", z, e7(0,0,1,0,2'b10,1));
        cyc("t3_flush3", z, e7(0,0,1,0,2'b10,1));
        cyc("t3_done", z, ze);

`ifdef BR_PERF_CNT_EN
        // Stall cycles so far: 2 (t1) + 1 (t2); redirects: t1 + t3
        checks++;
        assert (perf_stall_a === 16'd3) else begin
            errors++; $error("FAIL perf_stall_a observed=%0d expected=3", perf_stall_a);
        end
        checks++;
        assert (perf_taken_a === 16'd2) else begin
            errors++; $error("FAIL perf_taken_a observed=%0d expected=2", perf_taken_a);
        end
        checks++;
        assert (perf_stall_b === 16'd3) else begin
            errors++; $error("FAIL perf_stall_b observed=%0d expected=3", perf_stall_b);
        end
        checks++;
        assert (perf_taken_b === 16'd2) else begin
            errors++; $error("FAIL perf_taken_b observed=%0d expected=2", perf_taken_b);
        end
`endif

        // JALR x3 waits on EX writer of x3, then redirects with br_raw = 0
        instr_in(I_JALR_X3, 1'b0); ex_in(1'b1, 5'd3);
        cyc("jalr_stall", e7(1,1,0,0,2'b00,0), e7(1,1,0,0,2'b00,1));
        ex_in(1'b0, 5'd0);
        cyc("jalr_redirect", e7(0,0,1,1,2'b01,0), e7(0,0,1,1,2'b01,1));
        idle_in();
        cyc("jalr_flush2", z, e7(0,0,1,0,2'b10,1));
        cyc("jalr_flush3", z, e7(0,0,1,0,2'b10,1));

        // Non-control instruction with matching EX producer: no stall
        instr_in(I_ADD_RS1X1, 1'b1); ex_in(1'b1, 5'd1);
        cyc("alu_no_stall", z, ze);

        // 4: reset clears err, then a 4-cycle hazard trips the watchdog
        idle_in(); rst = 1'b1;
        cyc("t4_reset", z, z);
        rst = 1'b0;
        instr_in(I_BEQ_X1_X2, 1'b0); ex_in(1'b1, 5'd2);
        cyc("t4_stall1", e7(1,1,0,0,2'b00,0), e7(1,1,0,0,2'b00,0));
        cyc("t4_stall2", e7(1,1,0,0,2'b01,0), e7(1,1,0,0,2'b01,1));
        cyc("t4_stall3", e7(1,1,0,0,2'b01,1), e7(1,1,0,0,2'b01,1));
        cyc("t4_stall4", e7(1,1,0,0,2'b01,1), e7(1,1,0,0,2'b01,1));
        // upstream squash while waiting: no redirect even with br_raw = 1
        id_valid = 1'b0; br_raw = 1'b1;
        cyc("t4_squash", e7(0,0,0,0,2'b01,1), e7(0,0,0,0,2'b01,1));
        idle_in();
        cyc("t4_err_sticky", ze, ze);

        // 5: reset during the 2nd flush cycle, then a normal taken branch
        instr_in(I_BEQ_X1_X2, 1'b1);
        cyc("t5_take", e7(0,0,1,1,2'b00,1), e7(0,0,1,1,2'b00,1));
        idle_in(); rst = 1'b1;
        cyc("t5_rst_in_flush", z, z);
        rst = 1'b0;
        cyc("t5_idle_after_rst", z, z);
        instr_in(I_BEQ_X1_X2, 1'b0);
        cyc("t5_br_not_taken", z, z);
        instr_in(I_BEQ_X1_X2, 1'b1);
        cyc("t5_br_taken", e7(0,0,1,1,2'b00,0), e7(0,0,1,1,2'b00,0));
        idle_in();
        cyc("t5_flush2", z, e7(0,0,1,0,2'b10,0));
        cyc("t5_flush3", z, e7(0,0,1,0,2'b10,0));
        cyc("t5_done", z, z);

        // Reset in the middle of a wait returns to IDLE
        instr_in(I_BEQ_X1_X2, 1'b1); mem_in(1'b1, 5'd2);
        cyc("rw_stall", e7(1,1,0,0,2'b00,0), e7(1,1,0,0,2'b00,0));
        rst = 1'b1;
        cyc("rw_rst", z, z);
        rst = 1'b0; idle_in();
        cyc("rw_idle", z, z);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
